// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// default buffer depth, buffer entry layout and immediate field bounds.
package fetch_pkg;

    localparam int FIFO_DEPTH_DEF = 2;

    localparam int IMM26_MSB = 25;
    localparam int IMM26_LSB = 0;
    localparam int IMM16_MSB = 15;
    localparam int IMM16_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer holding {fetch address, instruction word} pairs.
// Flush wins over push and pop; pointers wrap naturally (depth is a power of two).
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             push_data,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop && !flush && (count != '0);
    assign do_push = push && !flush && ((count != FULL) || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible while count != 0.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding memory request feeding a small buffer toward decode.
// Define FETCH_ALIGN_CHECK_EN to add the sticky misalign_err output and alignment gating.
//
// state | meaning
// IDLE  | after reset/flush; decides whether a request may be issued
// FETCH | request outstanding, imem_addr held until imem_ack
// HOLD  | buffer full, waiting for decode to pop an entry
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        flush,
    output logic        IncPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [25:0] Imm26,
    output logic [15:0] Imm16
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_e  state;
    fetch_state_e  state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          accept;
    logic          push;
    logic          pop;
    logic          load_addr;
    logic          load_seq;
    logic          addr_bad;
    logic [31:0]   fetch_addr;
    fetch_entry_t  push_data;
    fetch_entry_t  head;

`ifdef FETCH_ALIGN_CHECK_EN
    logic err_q;

    assign fetch_addr   = address;
    assign addr_bad     = (address[1:0] != 2'b00) || err_q;
    assign misalign_err = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (flush) begin
            err_q <= 1'b0;
        end else if (state == IDLE && count < DEPTH_C && address[1:0] != 2'b00) begin
            err_q <= 1'b1;
        end
    end
`else
    assign fetch_addr = address & 32'hFFFF_FFFC;
    assign addr_bad   = 1'b0;
`endif

    assign accept     = (state == FETCH) && imem_ack && !flush;
    assign push       = accept;
    assign pop        = instr_valid && instr_ready && !flush;
    assign count_next = count + CW'(push) - CW'(pop);

    assign IncPC      = accept;
    assign imem_req   = (state == FETCH);
    assign push_data  = '{pc: imem_addr, word: imem_rdata};

    // A new request is only entered when the post-cycle count leaves a free slot,
    // so the single outstanding ack can always be pushed.
    always_comb begin
        state_next = state;
        load_addr  = 1'b0;
        load_seq   = 1'b0;
        if (flush) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (count >= DEPTH_C) begin
                        state_next = HOLD;
                    end else if (!addr_bad) begin
                        state_next = FETCH;
                        load_addr  = 1'b1;
                    end
                end
                FETCH: begin
                    if (accept) begin
                        if (count_next < DEPTH_C) begin
                            state_next = FETCH;
                            load_seq   = 1'b1;
                        end else begin
                            state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (count_next < DEPTH_C) begin
                        state_next = FETCH;
                        load_addr  = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Back-to-back fetch: the PC advances on this cycle's IncPC, so the input
    // still shows the old value at this edge; use the next sequential word instead.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_addr <= '0;
        end else if (load_addr) begin
            imem_addr <= fetch_addr;
        end else if (load_seq) begin
            imem_addr <= next_word_addr(imem_addr);
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data (push_data),
        .head      (head),
        .count     (count)
    );

    assign instr_valid = (count != '0);
    assign instr       = head.word;
    assign instr_pc    = head.pc;
    assign Imm26       = instr[IMM26_MSB:IMM26_LSB];
    assign Imm16       = instr[IMM16_MSB:IMM16_LSB];

endmodule
